clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/clint.sv | 158 +++++++++++++++
 tb/tb_clint.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime
// behind a single-outstanding valid/ready register port.
module clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        timer_int,
  output logic        soft_int
);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] presc;
  logic [15:0] presc_next;
  logic [63:0] mtime;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp;
  logic [63:0] cmp_next;
  logic        msip;
  logic        msip_next;

  logic        accept;
  logic        wr;
  logic        tick;
  logic [13:0] word;
  logic        sel_msip;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_time_lo;
  logic        sel_time_hi;
  logic        mapped;
  logic [31:0] rdata;
  logic        addr_unused;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  assign addr_unused = ^req_addr[1:0];
  assign word        = req_addr[15:2];
  assign sel_msip    = (word == 14'h0000);
  assign sel_cmp_lo  = (word == 14'h1000);
  assign sel_cmp_hi  = (word == 14'h1001);
  assign sel_time_lo = (word == 14'h2ffe);
  assign sel_time_hi = (word == 14'h2fff);
  assign mapped      = sel_msip | sel_cmp_lo | sel_cmp_hi
                     | sel_time_lo | sel_time_hi;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign wr         = accept && req_write;
  assign soft_int   = msip;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_valid) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_msip:    rdata = {31'd0, msip};
      sel_cmp_lo:  rdata = mtimecmp[31:0];
      sel_cmp_hi:  rdata = mtimecmp[63:32];
      sel_time_lo: rdata = mtime[31:0];
      sel_time_hi: rdata = mtime[63:32];
      default:     rdata = '0;
    endcase
  end

  assign tick       = (presc == PRESC_MAX);
  assign presc_next = tick ? '0 : presc + 16'd1;

  // A software write to either mtime half takes the place of that
  // cycle's increment; the prescaler keeps running regardless.
  always_comb begin
    msip_next  = msip;
    cmp_next   = mtimecmp;
    mtime_next = tick ? mtime + 64'd1 : mtime;
    if (wr) begin
      unique case (1'b1)
        sel_msip: begin
          if (req_wstrb[0]) msip_next = req_wdata[0];
        end
        sel_cmp_lo: begin
          cmp_next[31:0] = merge(mtimecmp[31:0], req_wdata, req_wstrb);
        end
        sel_cmp_hi: begin
          cmp_next[63:32] = merge(mtimecmp[63:32], req_wdata, req_wstrb);
        end
        sel_time_lo: begin
          mtime_next = {mtime[63:32],
                        merge(mtime[31:0], req_wdata, req_wstrb)};
        end
        sel_time_hi: begin
          mtime_next = {merge(mtime[63:32], req_wdata, req_wstrb),
                        mtime[31:0]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      presc      <= '0;
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      timer_int  <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      mtime     <= mtime_next;
      mtimecmp  <= cmp_next;
      msip      <= msip_next;
      timer_int <= (mtime >= mtimecmp);
      if (accept) begin
        resp_rdata <= req_write ? '0 : rdata;
        resp_err   <= !mapped;
      end
    end
  end

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (TICK_DIV 1 and 4) share one bus
// stimulus and are compared every cycle against a behavioural model.
module tb_clint;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_ready;

  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        timer_int  [2];
  logic        soft_int   [2];

  always #5 clock = ~clock;

  clint #(.TICK_DIV(1)) u_div1 (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready[0]),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0]),
    .timer_int  (timer_int[0]),
    .soft_int   (soft_int[0])
  );

  clint #(.TICK_DIV(4)) u_div4 (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready[1]),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1]),
    .timer_int  (timer_int[1]),
    .soft_int   (soft_int[1])
  );

  // Model state: what software would observe after each clock edge.
  logic [63:0]     m_time  [2];
  logic [63:0]     m_cmp   [2];
  logic            m_msip  [2];
  logic            m_tint  [2];
  logic            m_busy  [2];
  logic            m_err   [2];
  logic [31:0]     m_rdata [2];
  longint unsigned m_cyc   [2];

  logic [31:0] last_rdata [2];
  logic        last_err   [2];
  logic [31:0] held_rdata [2];
  logic        held_err   [2];

  int checks = 0;
  int errors = 0;

  function automatic longint unsigned div_of(input int k);
    return (k == 0) ? 64'd1 : 64'd4;
  endfunction

  function automatic logic [31:0] bytes_merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] a;
    logic [31:0] rd;
    logic        err;
    logic        cond;
    logic [63:0] nt;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_time[k]  = '0;
        m_cmp[k]   = '1;
        m_msip[k]  = 1'b0;
        m_tint[k]  = 1'b0;
        m_busy[k]  = 1'b0;
        m_err[k]   = 1'b0;
        m_rdata[k] = '0;
        m_cyc[k]   = 0;
      end else begin
        cond = (m_time[k] >= m_cmp[k]);
        nt   = m_time[k];
        if (m_cyc[k] % div_of(k) == div_of(k) - 1) nt = nt + 64'd1;
        m_cyc[k]++;
        if (req_valid && !m_busy[k]) begin
          a   = {req_addr[15:2], 2'b00};
          rd  = '0;
          err = 1'b0;
          case (a)
            16'h0000: begin
              rd = {31'd0, m_msip[k]};
              if (req_write && req_wstrb[0]) m_msip[k] = req_wdata[0];
            end
            16'h4000: begin
              rd = m_cmp[k][31:0];
              if (req_write)
                m_cmp[k][31:0] = bytes_merge(m_cmp[k][31:0],
                                             req_wdata, req_wstrb);
            end
            16'h4004: begin
              rd = m_cmp[k][63:32];
              if (req_write)
                m_cmp[k][63:32] = bytes_merge(m_cmp[k][63:32],
                                              req_wdata, req_wstrb);
            end
            16'hbff8: begin
              rd = m_time[k][31:0];
              if (req_write)
                nt = {m_time[k][63:32],
                      bytes_merge(m_time[k][31:0], req_wdata, req_wstrb)};
            end
            16'hbffc: begin
              rd = m_time[k][63:32];
              if (req_write)
                nt = {bytes_merge(m_time[k][63:32], req_wdata, req_wstrb),
                      m_time[k][31:0]};
            end
            default: err = 1'b1;
          endcase
          m_busy[k]  = 1'b1;
          m_rdata[k] = req_write ? 32'd0 : rd;
          m_err[k]   = err;
        end else if (m_busy[k] && resp_ready) begin
          m_busy[k] = 1'b0;
        end
        m_time[k] = nt;
        m_tint[k] = cond;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d req_ready", k), req_ready[k], !m_busy[k]);
      chk($sformatf("d%0d resp_valid", k), resp_valid[k], m_busy[k]);
      chk($sformatf("d%0d resp_rdata", k), resp_rdata[k], m_rdata[k]);
      chk($sformatf("d%0d resp_err", k), resp_err[k], m_err[k]);
      chk($sformatf("d%0d timer_int", k), timer_int[k], m_tint[k]);
      chk($sformatf("d%0d soft_int", k), soft_int[k], m_msip[k]);
    end
  endtask

  task automatic bus(input logic wr, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = d;
    req_wstrb  = s;
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d bus resp", k), resp_valid[k], 1'b1);
      last_rdata[k] = resp_rdata[k];
      last_err[k]   = resp_err[k];
    end
    step();
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      chk("reset req_ready", req_ready[k], 1'b1);
      chk("reset resp_valid", resp_valid[k], 1'b0);
      chk("reset timer_int", timer_int[k], 1'b0);
      chk("reset soft_int", soft_int[k], 1'b0);
    end

    reset = 1'b1;
    repeat (10) step();
    bus(1'b0, 16'hbff8, '0, '0);
    chk("mtime idle10 div1", last_rdata[0], 32'd10);
    chk("mtime idle10 div4", last_rdata[1], 32'd2);
    chk("idle timer_int", timer_int[0], 1'b0);

    bus(1'b1, 16'h4004, 32'd0, 4'hf);
    bus(1'b1, 16'h4000, 32'd20, 4'hf);
    for (int i = 0; i < 40 && m_time[0] != 64'd20; i++) step();
    chk("timer at mtime=20", timer_int[0], 1'b0);
    step();
    chk("timer after mtime=20", timer_int[0], 1'b1);
    bus(1'b1, 16'h4004, 32'd1, 4'hf);
    chk("timer after cmp hi", timer_int[0], 1'b0);

    bus(1'b1, 16'h0000, 32'd1, 4'hf);
    chk("msip set d1", soft_int[0], 1'b1);
    chk("msip set d4", soft_int[1], 1'b1);
    bus(1'b1, 16'h0000, 32'd0, 4'h1);
    chk("msip clr", soft_int[0], 1'b0);
    bus(1'b1, 16'h0000, 32'd1, 4'h0);
    chk("msip strb0", soft_int[0], 1'b0);

    bus(1'b1, 16'hbffc, 32'hffff_ffff, 4'hf);
    bus(1'b1, 16'hbff8, 32'hffff_ffff, 4'hf);
    repeat (4) step();
    bus(1'b0, 16'hbffc, '0, '0);
    chk("wrap hi d1", last_rdata[0], 32'd0);
    chk("wrap hi d4", last_rdata[1], 32'd0);
    bus(1'b0, 16'hbff8, '0, '0);
    chk("wrap lo small d1", last_rdata[0] < 32'd16, 1'b1);
    chk("wrap lo small d4", last_rdata[1] < 32'd16, 1'b1);

    bus(1'b0, 16'h1234, '0, '0);
    chk("unmapped err", last_err[0], 1'b1);
    chk("unmapped rdata", last_rdata[0], 32'd0);
    bus(1'b1, 16'h1234, 32'hdead_beef, 4'hf);
    chk("unmapped wr err", last_err[1], 1'b1);

    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 16'hbff8;
    resp_ready = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      held_rdata[k] = resp_rdata[k];
      held_err[k]   = resp_err[k];
    end
    req_addr = 16'h4000;
    repeat (5) begin
      step();
      for (int k = 0; k < 2; k++) begin
        chk("hold resp_valid", resp_valid[k], 1'b1);
        chk("hold rdata", resp_rdata[k], held_rdata[k]);
        chk("hold err", resp_err[k], held_err[k]);
        chk("hold req_ready", req_ready[k], 1'b0);
      end
    end
    resp_ready = 1'b1;
    step();
    chk("handshake resp_valid", resp_valid[0], 1'b0);
    chk("handshake req_ready", req_ready[0], 1'b1);
    step();
    chk("second accepted", resp_valid[0], 1'b1);
    chk("second rdata d1", resp_rdata[0], 32'd20);
    chk("second rdata d4", resp_rdata[1], 32'd20);
    req_valid = 1'b0;
    step();

    bus(1'b1, 16'h0000, 32'd1, 4'hf);
    req_valid  = 1'b1;
    req_addr   = 16'h4004;
    resp_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("rst resp_valid", resp_valid[k], 1'b0);
      chk("rst rdata", resp_rdata[k], 32'd0);
      chk("rst err", resp_err[k], 1'b0);
      chk("rst soft_int", soft_int[k], 1'b0);
      chk("rst req_ready", req_ready[k], 1'b1);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    reset = 1'b1;
    repeat (8) step();
    chk("no stale resp", resp_valid[0], 1'b0);
    bus(1'b0, 16'hbff8, '0, '0);
    chk("rst mtime d1", last_rdata[0], 32'd8);
    chk("rst mtime d4", last_rdata[1], 32'd2);
    repeat (4) step();
    bus(1'b0, 16'hbff8, '0, '0);
    chk("div4 advance", last_rdata[1], 32'd3);
    chk("div1 advance", last_rdata[0], 32'd14);
    bus(1'b0, 16'h4004, '0, '0);
    chk("rst cmp hi", last_rdata[1], 32'hffff_ffff);

    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: req_addr = 16'h0000;
        1: req_addr = 16'h4000;
        2: req_addr = 16'h4004;
        3: req_addr = 16'hbff8;
        4: req_addr = 16'hbffc;
        default: req_addr = 16'($urandom_range(0, 65535));
      endcase
      req_wdata  = $urandom;
      req_wstrb  = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    reset      = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
